fifo_push_arbiter: RTL

- Round-robin arbiter that shares the single push port of a FiFo (nWE/DIN/FULL interface) among REQ_COUNT requesters.
- Each granted requester owns the port for a burst. The burst ends on its LAST beat, after BURST_MAX beats, or when it idles.
- Every pushed word carries the requester ID in its upper bits, so the pop side can demultiplex.
- Sits between producer blocks and the FiFo write side. The FiFo's DATA_WIDTH must equal ID_WIDTH+DATA_WIDTH of this block.

---
 rtl/fifo_push_arbiter_if.sv | 28 ++
 rtl/fifo_push_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle shared by the requesters, the arbiter and the FiFo write port.
// The master modport is the arbiter's view; slave is the surrounding producers/FiFo.
interface fifo_push_arbiter_if #(
  parameter int unsigned REQ_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) ();
  logic [REQ_COUNT-1:0]            REQ_VALID;
  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA;
  logic [REQ_COUNT-1:0]            REQ_LAST;
  logic [REQ_COUNT-1:0]            REQ_READY;
  logic                            FIFO_nWE;
  logic [ID_WIDTH+DATA_WIDTH-1:0]  FIFO_DIN;
  logic                            FIFO_FULL;
  logic                            GRANT_VALID;
  logic [ID_WIDTH-1:0]             GRANT_ID;
  logic                            BUSY;

  modport master (
    input  REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
    output REQ_READY, FIFO_nWE, FIFO_DIN, GRANT_VALID, GRANT_ID, BUSY
  );

  modport slave (
    output REQ_VALID, REQ_DATA, REQ_LAST, FIFO_FULL,
    input  REQ_READY, FIFO_nWE, FIFO_DIN, GRANT_VALID, GRANT_ID, BUSY
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FiFo push port among REQ_COUNT bursting requesters.
// Each pushed word is tagged {GRANT_ID, payload}; the data path is purely combinational.
module fifo_push_arbiter #(
  parameter int unsigned REQ_COUNT  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                 MCLK,
  input  logic                 nRST,
  fifo_push_arbiter_if.master  bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;

  logic                  found;
  logic [ID_WIDTH-1:0]   winner;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  beat;

  // Round-robin search: first the indices above last_grant, then wrap to 0..last_grant.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < int'(REQ_COUNT); i++) begin
      if (!found && bus.REQ_VALID[i] && (ID_WIDTH'(i) > last_grant_q)) begin
        found  = 1'b1;
        winner = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(REQ_COUNT); i++) begin
      if (!found && bus.REQ_VALID[i] && (ID_WIDTH'(i) <= last_grant_q)) begin
        found  = 1'b1;
        winner = ID_WIDTH'(i);
      end
    end
  end

  // Mux out the granted requester's signals and drive its ready.
  always_comb begin
    g_valid       = 1'b0;
    g_last        = 1'b0;
    g_data        = '0;
    bus.REQ_READY = '0;
    for (int i = 0; i < int'(REQ_COUNT); i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        g_valid = bus.REQ_VALID[i];
        g_last  = bus.REQ_LAST[i];
        g_data  = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == StGrant) begin
          bus.REQ_READY[i] = ~bus.FIFO_FULL;
        end
      end
    end
  end

  assign beat            = (state_q == StGrant) && g_valid && !bus.FIFO_FULL;
  assign bus.FIFO_nWE    = ~beat;
  assign bus.FIFO_DIN    = (state_q == StGrant) ? {grant_id_q, g_data} : '0;
  assign bus.GRANT_VALID = grant_valid_q;
  assign bus.GRANT_ID    = grant_id_q;
  assign bus.BUSY        = grant_valid_q | (|bus.REQ_VALID);

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StGrant;
          grant_valid_d = 1'b1;
          grant_id_d    = winner;
          last_grant_d  = winner;
          beat_cnt_d    = '0;
        end
      end
      StGrant: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (g_last || (beat_cnt_q == 8'(BURST_MAX - 1))) begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
          end
        end else if (!bus.FIFO_FULL && !g_valid) begin
          // Requester went idle while the FiFo could accept: give the port up.
          state_d       = StIdle;
          grant_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= ID_WIDTH'(REQ_COUNT - 1);
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

endmodule
